// File: rtl/overlay_text_sequencer_if.sv
// Host register-write port of the overlay text sequencer.
// One register per accepted beat (wr_valid & wr_ready on a clk edge).
interface overlay_text_sequencer_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_sel;
    logic [11:0] wr_data;

    modport master (output wr_valid, output wr_sel, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_ready);
endinterface

// File: rtl/overlay_text_sequencer.sv
// Sequences font-ROM addresses so a string of up to MAX_CHARS glyphs lands at a programmable position.
// Latency: address 1 cycle after the pixel; sideband (syncs, DE, overlay_enable) 1+ROM_LAT cycles.
// Backpressure: wr_ready drops only for the single commit cycle at the vs_in falling edge.
module overlay_text_sequencer #(
    parameter int MAX_CHARS = 8,
    parameter int ROM_LAT   = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           hdmi_hs_in,
    input  logic                           hdmi_vs_in,
    input  logic                           hdmi_de_in,
    overlay_text_sequencer_if.slave        wr,
    output logic [12:0]                    rom_address,
    input  logic                           rom_q,
    output logic                           overlay_enable,
    output logic                           hdmi_hs_out,
    output logic                           hdmi_vs_out,
    output logic                           hdmi_de_out,
    output logic                           commit_pulse
);
    localparam int IDXW = $clog2(MAX_CHARS);

    typedef enum logic {RUN, COMMIT} state_e;

    typedef struct packed {
        logic [11:0]               x_pos;
        logic [11:0]               y_pos;
        logic [4:0]                len;
        logic [MAX_CHARS-1:0][3:0] chars;
    } regs_t;

    typedef struct packed {
        logic hit;
        logic hs;
        logic vs;
        logic de;
    } side_t;

    localparam regs_t REGS_RST = '{x_pos: 12'd300, y_pos: 12'd500, len: 5'd0, chars: '0};
    localparam side_t SIDE_RST = '{hit: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b0};

    state_e              state_q, state_d;
    regs_t               shadow_q, shadow_d;
    regs_t               active_q, active_d;
    logic [11:0]         x_cnt_q, x_cnt_d;
    logic [11:0]         y_cnt_q, y_cnt_d;
    logic                y_vld_q, y_vld_d;
    logic                de_q, vs_q;
    logic [12:0]         rom_addr_q, rom_addr_d;
    side_t [ROM_LAT:0]   side_q;
    side_t               side_d;

    logic                vs_fall, de_fall, wr_fire, hit;
    logic [12:0]         dx, dy, box_w;
    logic [IDXW-1:0]     idx;
    logic [3:0]          code;
    logic                unused_rom_q;

    // rom_q goes straight to the bit combiner; only its timing matters here
    assign unused_rom_q = rom_q;

    assign vs_fall = vs_q & ~hdmi_vs_in;
    assign de_fall = de_q & ~hdmi_de_in;
    assign wr.wr_ready = (state_q == RUN);
    assign wr_fire = wr.wr_valid & wr.wr_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (vs_fall) state_d = COMMIT;
            COMMIT:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        if (wr_fire) begin
            case (wr.wr_sel)
                4'd12: shadow_d.x_pos = wr.wr_data;
                4'd13: shadow_d.y_pos = wr.wr_data;
                4'd14: shadow_d.len = (wr.wr_data[4:0] > 5'(MAX_CHARS)) ? 5'(MAX_CHARS)
                                                                        : wr.wr_data[4:0];
                default: begin
                    if ({28'd0, wr.wr_sel} < 32'(MAX_CHARS))
                        shadow_d.chars[wr.wr_sel[IDXW-1:0]] = wr.wr_data[3:0];
                end
            endcase
        end
        active_d = (state_q == COMMIT) ? shadow_q : active_q;
    end

    always_comb begin
        x_cnt_d = hdmi_de_in ? x_cnt_q + 12'd1 : 12'd0;
        y_cnt_d = y_cnt_q;
        if (!hdmi_vs_in)
            y_cnt_d = 12'd0;
        else if (de_fall)
            y_cnt_d = y_cnt_q + 12'd1;
        // y_cnt is meaningless until the first vertical sync after reset
        y_vld_d = y_vld_q | ~hdmi_vs_in;
    end

    // Negative offsets set bit 12 and therefore also fail the unsigned box compares
    always_comb begin
        dx    = {1'b0, x_cnt_q} - {1'b0, active_q.x_pos};
        dy    = {1'b0, y_cnt_q} - {1'b0, active_q.y_pos};
        box_w = {4'd0, active_q.len, 4'd0};
        hit   = hdmi_de_in & y_vld_q & (active_q.len != 5'd0) & ~dx[12] & ~dy[12]
              & (dx < box_w) & (dy < 13'd32);
        idx   = dx[IDXW+3:4];
        code  = active_q.chars[idx];
        rom_addr_d = hit ? {code, dy[4:0], dx[3:0]} : rom_addr_q;
        side_d = '{hit: hit, hs: hdmi_hs_in, vs: hdmi_vs_in, de: hdmi_de_in};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            shadow_q   <= REGS_RST;
            active_q   <= REGS_RST;
            x_cnt_q    <= 12'd0;
            y_cnt_q    <= 12'd0;
            y_vld_q    <= 1'b0;
            de_q       <= 1'b0;
            vs_q       <= 1'b1;
            rom_addr_q <= 13'd0;
            side_q     <= {(ROM_LAT+1){SIDE_RST}};
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            y_vld_q    <= y_vld_d;
            de_q       <= hdmi_de_in;
            vs_q       <= hdmi_vs_in;
            rom_addr_q <= rom_addr_d;
            side_q     <= {side_q[ROM_LAT-1:0], side_d};
        end
    end

    assign rom_address    = rom_addr_q;
    assign overlay_enable = side_q[ROM_LAT].hit;
    assign hdmi_hs_out    = side_q[ROM_LAT].hs;
    assign hdmi_vs_out    = side_q[ROM_LAT].vs;
    assign hdmi_de_out    = side_q[ROM_LAT].de;
    assign commit_pulse   = (state_q == COMMIT);
endmodule

// File: tb/tb_overlay_text_sequencer.sv
// Directed bench for overlay_text_sequencer on a reduced 160x48 raster (176x52 total).
// Per-frame overlay box, ROM address probes, sync delay and commit behaviour against hand values.
module tb_overlay_text_sequencer;
    localparam int H_ACT = 160, H_FP = 4, H_SYNC = 4, H_TOT = 176;
    localparam int V_ACT = 48,  V_FP = 1, V_SYNC = 2, V_TOT = 52;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [7:0] h;
        logic [7:0] v;
    } smp_t;

    logic        clk, reset_n;
    logic        hs_in, vs_in, de_in, rom_q;
    logic [7:0]  cur_h, cur_v;
    logic [12:0] rom_address;
    logic        overlay_enable, hdmi_hs_out, hdmi_vs_out, hdmi_de_out, commit_pulse;

    overlay_text_sequencer_if wr_if ();

    overlay_text_sequencer #(.MAX_CHARS(8), .ROM_LAT(1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hdmi_hs_in     (hs_in),
        .hdmi_vs_in     (vs_in),
        .hdmi_de_in     (de_in),
        .wr             (wr_if),
        .rom_address    (rom_address),
        .rom_q          (rom_q),
        .overlay_enable (overlay_enable),
        .hdmi_hs_out    (hdmi_hs_out),
        .hdmi_vs_out    (hdmi_vs_out),
        .hdmi_de_out    (hdmi_de_out),
        .commit_pulse   (commit_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: outputs lag inputs by two cycles, the ROM address by one
    smp_t        cur_s, hist0, hist1;
    int          hist_n, sync_err, ov_cnt, commit_cnt;
    logic [7:0]  ov_xmin, ov_xmax, ov_ymin, ov_ymax;
    logic [7:0]  probe_x [3];
    logic [7:0]  probe_y [3];
    logic [15:0] probe_val [3];

    assign cur_s = {hs_in, vs_in, de_in, cur_h, cur_v};

    initial sync_err = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            hist_n     <= 0;
            ov_cnt     <= 0;
            commit_cnt <= 0;
            ov_xmin    <= 8'hFF;
            ov_xmax    <= 8'h00;
            ov_ymin    <= 8'hFF;
            ov_ymax    <= 8'h00;
            for (int i = 0; i < 3; i++) probe_val[i] <= 16'hFFFF;
        end else begin
            hist0 <= cur_s;
            hist1 <= hist0;
            if (hist_n < 2) hist_n <= hist_n + 1;
            if (hist_n >= 2 && {hdmi_hs_out, hdmi_vs_out, hdmi_de_out} !== {hist1.hs, hist1.vs, hist1.de})
                sync_err <= sync_err + 1;
            if (cur_h == 8'd0 && cur_v == 8'd0) begin
                ov_cnt     <= 0;
                commit_cnt <= 0;
                ov_xmin    <= 8'hFF;
                ov_xmax    <= 8'h00;
                ov_ymin    <= 8'hFF;
                ov_ymax    <= 8'h00;
                for (int i = 0; i < 3; i++) probe_val[i] <= 16'hFFFF;
            end else begin
                if (hist_n >= 2 && overlay_enable) begin
                    ov_cnt <= ov_cnt + 1;
                    if (hist1.h < ov_xmin) ov_xmin <= hist1.h;
                    if (hist1.h > ov_xmax) ov_xmax <= hist1.h;
                    if (hist1.v < ov_ymin) ov_ymin <= hist1.v;
                    if (hist1.v > ov_ymax) ov_ymax <= hist1.v;
                end
                if (commit_pulse) commit_cnt <= commit_cnt + 1;
                for (int i = 0; i < 3; i++)
                    if (hist_n >= 1 && hist0.de && hist0.h == probe_x[i] && hist0.v == probe_y[i])
                        probe_val[i] <= {3'd0, rom_address};
            end
        end
    end

    task automatic gen_frame();
        for (int v = 0; v < V_TOT; v++) begin
            for (int h = 0; h < H_TOT; h++) begin
                @(posedge clk);
                #1;
                cur_v = 8'(v);
                cur_h = 8'(h);
                de_in = (v < V_ACT) && (h < H_ACT);
                hs_in = !((h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYNC));
                vs_in = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYNC));
            end
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge
    task automatic host_wr(input logic [3:0] sel, input logic [11:0] dat, output int stalls);
        logic ok;
        ok     = 1'b0;
        stalls = 0;
        wr_if.wr_sel   = sel;
        wr_if.wr_data  = dat;
        wr_if.wr_valid = 1'b1;
        while (!ok && stalls < 8) begin
            @(negedge clk);
            if (wr_if.wr_ready) ok = 1'b1;
            else stalls++;
        end
        if (!ok) chk("wr_timeout", 32'(stalls), 32'd0);
        @(posedge clk);
        #1;
        wr_if.wr_valid = 1'b0;
    endtask

    int dmy, stall_n;

    initial begin
        reset_n = 1'b0;
        hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b0; rom_q = 1'b0;
        cur_h = 8'hFF; cur_v = 8'hFF;
        wr_if.wr_valid = 1'b0; wr_if.wr_sel = 4'd0; wr_if.wr_data = 12'd0;
        for (int i = 0; i < 3; i++) begin probe_x[i] = 8'hFF; probe_y[i] = 8'hFF; end

        repeat (3) @(negedge clk);
        chk("rst_rom_addr", 32'(rom_address), 32'd0);
        chk("rst_overlay",  32'(overlay_enable), 32'd0);
        chk("rst_commit",   32'(commit_pulse), 32'd0);
        chk("rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
        chk("rst_de_out",   32'(hdmi_de_out), 32'd0);
        chk("rst_hs_out",   32'(hdmi_hs_out), 32'd1);
        chk("rst_vs_out",   32'(hdmi_vs_out), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // F0: idle frame, nothing programmed
        gen_frame();
        chk("f0_ov_cnt", 32'(ov_cnt), 32'd0);
        chk("f0_sync",   32'(sync_err), 32'd0);
        chk("f0_commit", 32'(commit_cnt), 32'd1);

        // F1: program the string; still invisible this frame
        fork
            gen_frame();
            begin
                wait (cur_v == 8'd2);
                host_wr(4'd14, 12'd3, dmy);
                host_wr(4'd0, 12'd1, dmy);
                host_wr(4'd1, 12'd2, dmy);
                host_wr(4'd2, 12'd3, dmy);
                host_wr(4'd12, 12'd100, dmy);
                host_wr(4'd13, 12'd8, dmy);
            end
        join
        chk("f1_ov_cnt", 32'(ov_cnt), 32'd0);

        // F2: box x 100..147, y 8..39; mid-frame x_pos write; write held across commit
        probe_x[0] = 8'd116; probe_y[0] = 8'd13;
        fork
            gen_frame();
            begin
                wait (cur_v == 8'd20);
                host_wr(4'd12, 12'd40, dmy);
                wait (cur_v == 8'd49 && cur_h == 8'd1);
                host_wr(4'd14, 12'd20, stall_n);
            end
        join
        chk("f2_ov_cnt", 32'(ov_cnt), 32'd1536);
        chk("f2_xmin",   32'(ov_xmin), 32'd100);
        chk("f2_xmax",   32'(ov_xmax), 32'd147);
        chk("f2_ymin",   32'(ov_ymin), 32'd8);
        chk("f2_ymax",   32'(ov_ymax), 32'd39);
        chk("f2_rom_116_13", 32'(probe_val[0]), 32'h450);
        chk("f2_commit", 32'(commit_cnt), 32'd1);
        chk("commit_stall_cycles", 32'(stall_n), 32'd1);

        // F3: box moved to x 40..87; discarded selects written
        fork
            gen_frame();
            begin
                wait (cur_v == 8'd2);
                host_wr(4'd12, 12'd10, dmy);
                host_wr(4'd10, 12'hFFF, dmy);
                host_wr(4'd9, 12'hFFF, dmy);
            end
        join
        chk("f3_ov_cnt", 32'(ov_cnt), 32'd1536);
        chk("f3_xmin",   32'(ov_xmin), 32'd40);
        chk("f3_xmax",   32'(ov_xmax), 32'd87);

        // F4: len 20 saturated to 8 -> x 10..137
        probe_x[0] = 8'd26; probe_y[0] = 8'd13;
        probe_x[1] = 8'd45; probe_y[1] = 8'd39;
        probe_x[2] = 8'd97; probe_y[2] = 8'd8;
        fork
            gen_frame();
            begin
                wait (cur_v == 8'd2);
                host_wr(4'd12, 12'd150, dmy);
                host_wr(4'd14, 12'd2, dmy);
            end
        join
        chk("f4_ov_cnt", 32'(ov_cnt), 32'd4096);
        chk("f4_xmin",   32'(ov_xmin), 32'd10);
        chk("f4_xmax",   32'(ov_xmax), 32'd137);
        chk("f4_rom_26_13", 32'(probe_val[0]), 32'h450);
        chk("f4_rom_45_39", 32'(probe_val[1]), 32'h7F3);
        chk("f4_rom_97_8",  32'(probe_val[2]), 32'h007);
        for (int i = 0; i < 3; i++) begin probe_x[i] = 8'hFF; probe_y[i] = 8'hFF; end

        // F5: box at 150 with len 2 clipped at the line end
        gen_frame();
        chk("f5_ov_cnt", 32'(ov_cnt), 32'd320);
        chk("f5_xmin",   32'(ov_xmin), 32'd150);
        chk("f5_xmax",   32'(ov_xmax), 32'd159);

        // F6: reset in the middle of an overlay line
        fork
            gen_frame();
            begin
                wait (cur_v == 8'd10 && cur_h == 8'd155);
                @(negedge clk);
                chk("pre_rst_overlay", 32'(overlay_enable), 32'd1);
                #1 reset_n = 1'b0;
                #1;
                chk("mid_rst_overlay", 32'(overlay_enable), 32'd0);
                chk("mid_rst_de_out",  32'(hdmi_de_out), 32'd0);
                chk("mid_rst_hs_out",  32'(hdmi_hs_out), 32'd1);
                chk("mid_rst_vs_out",  32'(hdmi_vs_out), 32'd1);
                chk("mid_rst_rom",     32'(rom_address), 32'd0);
                chk("mid_rst_wr_rdy",  32'(wr_if.wr_ready), 32'd1);
                repeat (3) @(posedge clk);
                #1 reset_n = 1'b1;
            end
        join
        chk("f6_ov_after_rst", 32'(ov_cnt), 32'd0);

        // F7: defaults committed again, so no box
        gen_frame();
        chk("f7_ov_cnt", 32'(ov_cnt), 32'd0);
        chk("f7_commit", 32'(commit_cnt), 32'd1);
        chk("sync_delay_total", 32'(sync_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
